cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Exception/interrupt sequencer and write-port arbiter for the CP0 register file in the MIPS core. Accepts synchronous exceptions, hardware interrupts, `eret` and software `mtc0` writes. Serialises them onto the CP0 file's single address/write port (`a1`/`wd`/`cp0_w`) and reads back through `rd1`. Stalls the pipeline while a sequence runs and issues one PC redirect at the end of each exception or `eret`.

## Interface
Parameters:
- `EXC_VECTOR`, 32'h0000_0180: exception/interrupt handler PC.
- `WR_HOLD`, 5: cycles each CP0 access is held stable (1..15). Sized so the slow-sampling register file captures it.
- `REG_STATUS`, 12: CP0 Status index.
- `REG_CAUSE`, 13: CP0 Cause index.
- `REG_EPC`, 14: CP0 EPC index.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `exc_req` in 1: synchronous exception from pipeline.
- `exc_code` in 5: ExcCode for `exc_req`.
- `exc_pc` in 32: PC of the faulting instruction.
- `exc_bd` in 1: the faulting instruction sits in a branch delay slot.
- `int_pc` in 32: PC to resume at after an interrupt.
- `hw_int` in 6: hardware interrupt lines, level-sensitive.
- `eret_req` in 1: `eret` retiring.
- `sw_wr` in 1: `mtc0` request, held until `sw_ack`.
- `sw_addr` in 5: `mtc0`/`mfc0` register index.
- `sw_wdata` in 32: `mtc0` data.
- `sw_ack` out 1: one-cycle pulse; `mtc0` completed.
- `cp0_w` out 1: CP0 file write enable.
- `cp0_a1` out 5: CP0 file address.
- `cp0_wd` out 32: CP0 file write data.
- `cp0_rd1` in 32: CP0 file read data.
- `stall` out 1: pipeline hold.
- `redirect_valid` out 1: one-cycle pulse.
- `redirect_pc` out 32: new PC, valid with `redirect_valid`.

## Operation
- Shadow Status register (`st_ie`=bit0, `st_exl`=bit1, `st_im`=bits15:8), reset to all zero.
  - Any `mtc0` to `REG_STATUS` also updates the shadow from `sw_wdata`.
  - Status write data is always `{16'b0, st_im, 6'b0, st_exl, st_ie}`.
- `int_pend = |(hw_int & st_im[15:10]) & st_ie & ~st_exl`.
- Events are evaluated only in IDLE. Priority: `exc_req` > `int_pend` > `eret_req` > `sw_wr`. Lower-priority requests stay pending; the requester holds them.
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, E_RD, E_STAT, SW_WR, REDIR. A hold counter `hc` (0..WR_HOLD-1) runs in every state except IDLE/REDIR. The state advances when `hc==WR_HOLD-1`.
- Exception/interrupt accept (IDLE):
  - Latch code (interrupt → 0), PC (interrupt → `int_pc`), BD (interrupt → 0) and `hw_int`.
  - Sequence: W_EPC → W_CAUSE → W_STATUS → REDIR(`EXC_VECTOR`).
  - EPC = BD ? PC−4 : PC, 32-bit wrap.
  - Cause = `{bd,15'b0,hw_int_latched,2'b0,1'b0,code,2'b0}`.
  - W_STATUS sets `st_exl`=1 on entry.
- Eret accept:
  - E_RD drives `cp0_a1=REG_EPC`, `cp0_w=0`; latch `cp0_rd1` on the last hold cycle.
  - E_STAT clears `st_exl` on entry and writes Status.
  - REDIR(latched EPC).
- `mtc0` accept: SW_WR writes `sw_addr`/`sw_wdata` (latched at accept) for WR_HOLD cycles; `sw_ack` on the last cycle; then IDLE. No redirect.
- IDLE: `cp0_w=0`, `cp0_a1=sw_addr` (combinational, serves `mfc0`), `cp0_wd=0`.
- `stall = (state!=IDLE) | exc_req | int_pend | eret_req`.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `hc`=0, shadow 0, `cp0_w`=0, `cp0_wd`=0, `sw_ack`=0, `redirect_valid`=0, `redirect_pc`=0.
  - Reset mid-sequence abandons it: no further writes, no redirect.
- Accept edge T, H=WR_HOLD:
  - Exception: EPC write cycles T+1..T+H, Cause T+H+1..T+2H, Status T+2H+1..T+3H, `redirect_valid` at T+3H+1, IDLE at T+3H+2.
  - Eret: redirect at T+2H+1.
  - `mtc0`: `sw_ack` at T+H.
- `cp0_a1`/`cp0_wd` are stable for the full hold window; `cp0_w` is high every cycle of write windows.
- Requests arriving while not IDLE are ignored (stalled); `exc_req` must be held by the pipeline.
- Interrupt level is sampled once at accept; later `hw_int` changes do not alter Cause.
- Back-to-back: a new event may be accepted in the cycle after REDIR/last SW_WR cycle.

## Test plan
- Reset low 1 cycle → all outputs 0, `stall`=0, `cp0_a1`=`sw_addr`.
- `exc_req`, code 5'd4, `exc_pc`=32'h0040_0010, bd=1, H=5 → EPC write 32'h0040_000C cycles 1–5, Cause 32'h8000_0010 cycles 6–10, Status with EXL cycles 11–15, `redirect_pc`=32'h180 at cycle 16.
- `mtc0` Status 32'h0000_0401, then `hw_int`=6'b000001 → `sw_ack` at cycle 5, interrupt accepted, Cause 32'h0000_0400, EPC=`int_pc`.
- Preload EPC=32'h0040_0100, `eret_req` → `cp0_a1`=14 cycles 1–5, Status EXL=0 write, redirect 32'h0040_0100 at cycle 11.
- `exc_req` and `eret_req` and `sw_wr` simultaneous → exception sequence first, then eret, then `sw_ack`.
- Reset low during W_CAUSE → no Status write, no redirect, shadow cleared.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt sequencer: serialises EPC/Cause/Status updates, eret and
// mtc0 onto the single CP0 write port, holding each access for WR_HOLD cycles.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int          WR_HOLD    = 5,
  parameter logic [4:0]  REG_STATUS = 5'd12,
  parameter logic [4:0]  REG_CAUSE  = 5'd13,
  parameter logic [4:0]  REG_EPC    = 5'd14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic [31:0] int_pc,
  input  logic [5:0]  hw_int,
  input  logic        eret_req,
  input  logic        sw_wr,
  input  logic [4:0]  sw_addr,
  input  logic [31:0] sw_wdata,
  output logic        sw_ack,
  output logic        cp0_w,
  output logic [4:0]  cp0_a1,
  output logic [31:0] cp0_wd,
  input  logic [31:0] cp0_rd1,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_STATUS, E_RD, E_STAT, SW_WR, REDIR
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  hc_q, hc_d;
  logic        st_ie_q, st_ie_d, st_exl_q, st_exl_d;
  logic [7:0]  st_im_q, st_im_d;

  logic [31:0] epc_q, redir_q, swd_q;
  logic [4:0]  code_q, swa_q;
  logic        bd_q;
  logic [5:0]  hwint_q;

  logic        int_pend, hc_last;
  logic        take_exc, take_int, take_sw, take_epc_rd;
  logic [31:0] status_word, cause_word;

  assign int_pend    = (|(hw_int & st_im_q[7:2])) & st_ie_q & ~st_exl_q;
  assign hc_last     = (hc_q == 4'(WR_HOLD - 1));
  assign status_word = {16'b0, st_im_q, 6'b0, st_exl_q, st_ie_q};
  assign cause_word  = {bd_q, 15'b0, hwint_q, 2'b0, 1'b0, code_q, 2'b0};
  assign stall       = (state_q != IDLE) | exc_req | int_pend | eret_req;

  always_comb begin
    state_d        = state_q;
    st_ie_d        = st_ie_q;
    st_exl_d       = st_exl_q;
    st_im_d        = st_im_q;
    take_exc       = 1'b0;
    take_int       = 1'b0;
    take_sw        = 1'b0;
    take_epc_rd    = 1'b0;
    cp0_w          = 1'b0;
    cp0_a1         = sw_addr;
    cp0_wd         = 32'b0;
    sw_ack         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'b0;
    hc_d           = 4'd0;
    if (state_q != IDLE && state_q != REDIR)
      hc_d = hc_last ? 4'd0 : hc_q + 4'd1;

    case (state_q)
      IDLE: begin
        if (exc_req) begin
          take_exc = 1'b1;
          state_d  = W_EPC;
        end else if (int_pend) begin
          take_int = 1'b1;
          state_d  = W_EPC;
        end else if (eret_req) begin
          state_d  = E_RD;
        end else if (sw_wr) begin
          take_sw  = 1'b1;
          state_d  = SW_WR;
          if (sw_addr == REG_STATUS) begin
            st_ie_d  = sw_wdata[0];
            st_exl_d = sw_wdata[1];
            st_im_d  = sw_wdata[15:8];
          end
        end
      end
      W_EPC: begin
        cp0_w  = 1'b1;
        cp0_a1 = REG_EPC;
        cp0_wd = epc_q;
        if (hc_last) state_d = W_CAUSE;
      end
      W_CAUSE: begin
        cp0_w  = 1'b1;
        cp0_a1 = REG_CAUSE;
        cp0_wd = cause_word;
        if (hc_last) begin
          state_d  = W_STATUS;
          st_exl_d = 1'b1;
        end
      end
      W_STATUS: begin
        cp0_w  = 1'b1;
        cp0_a1 = REG_STATUS;
        cp0_wd = status_word;
        if (hc_last) state_d = REDIR;
      end
      E_RD: begin
        cp0_a1 = REG_EPC;
        if (hc_last) begin
          take_epc_rd = 1'b1;
          state_d     = E_STAT;
          st_exl_d    = 1'b0;
        end
      end
      E_STAT: begin
        cp0_w  = 1'b1;
        cp0_a1 = REG_STATUS;
        cp0_wd = status_word;
        if (hc_last) state_d = REDIR;
      end
      SW_WR: begin
        cp0_w  = 1'b1;
        cp0_a1 = swa_q;
        // Status writes go out in the canonical shadow format
        cp0_wd = (swa_q == REG_STATUS) ? status_word : swd_q;
        if (hc_last) begin
          sw_ack  = 1'b1;
          state_d = IDLE;
        end
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = redir_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      hc_q     <= 4'd0;
      st_ie_q  <= 1'b0;
      st_exl_q <= 1'b0;
      st_im_q  <= 8'b0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      st_ie_q  <= st_ie_d;
      st_exl_q <= st_exl_d;
      st_im_q  <= st_im_d;
    end
  end

  // Sequence payload; only ever observed through state-gated outputs, so no reset
  always_ff @(posedge clk) begin
    if (take_exc) begin
      epc_q   <= exc_bd ? exc_pc - 32'd4 : exc_pc;
      code_q  <= exc_code;
      bd_q    <= exc_bd;
      hwint_q <= hw_int;
      redir_q <= EXC_VECTOR;
    end else if (take_int) begin
      epc_q   <= int_pc;
      code_q  <= 5'd0;
      bd_q    <= 1'b0;
      hwint_q <= hw_int;
      redir_q <= EXC_VECTOR;
    end else if (take_epc_rd) begin
      redir_q <= cp0_rd1;
    end
    if (take_sw) begin
      swa_q <= sw_addr;
      swd_q <= sw_wdata;
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl with WR_HOLD=5: exception, interrupt, eret,
// mtc0, simultaneous requests and reset in the middle of a sequence.
module tb_cp0_exc_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] int_pc;
  logic [5:0]  hw_int;
  logic        eret_req;
  logic        sw_wr;
  logic [4:0]  sw_addr;
  logic [31:0] sw_wdata;
  logic        sw_ack;
  logic        cp0_w;
  logic [4:0]  cp0_a1;
  logic [31:0] cp0_wd;
  logic [31:0] cp0_rd1;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .int_pc(int_pc), .hw_int(hw_int), .eret_req(eret_req),
    .sw_wr(sw_wr), .sw_addr(sw_addr), .sw_wdata(sw_wdata), .sw_ack(sw_ack),
    .cp0_w(cp0_w), .cp0_a1(cp0_a1), .cp0_wd(cp0_wd), .cp0_rd1(cp0_rd1),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept edge, then EPC 1..5, Cause 6..10, Status 11..15, redirect 16, idle 17
  task automatic exc_seq(input logic [31:0] epc, input logic [31:0] cause,
                         input logic [31:0] stat);
    step();
    exc_req = 1'b0;
    hw_int  = 6'b100000;
    for (int c = 1; c <= 15; c++) begin
      chk("exc_w", {31'b0, cp0_w}, 32'd1);
      chk("exc_a1", {27'b0, cp0_a1}, (c <= 5) ? 32'd14 : (c <= 10) ? 32'd13 : 32'd12);
      chk("exc_wd", cp0_wd, (c <= 5) ? epc : (c <= 10) ? cause : stat);
      chk("exc_ack", {31'b0, sw_ack}, 32'd0);
      chk("exc_stall", {31'b0, stall}, 32'd1);
      chk("exc_rv", {31'b0, redirect_valid}, 32'd0);
      step();
    end
    chk("exc_redir_v", {31'b0, redirect_valid}, 32'd1);
    chk("exc_redir_pc", redirect_pc, 32'h0000_0180);
    chk("exc_redir_w", {31'b0, cp0_w}, 32'd0);
    hw_int = 6'b0;
    step();
    chk("exc_idle_rv", {31'b0, redirect_valid}, 32'd0);
    chk("exc_idle_w", {31'b0, cp0_w}, 32'd0);
  endtask

  // Accept edge, EPC read 1..5, Status 6..10, redirect 11, idle 12
  task automatic eret_seq(input logic [31:0] stat, input logic [31:0] target);
    step();
    eret_req = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      chk("eret_w", {31'b0, cp0_w}, (c <= 5) ? 32'd0 : 32'd1);
      chk("eret_a1", {27'b0, cp0_a1}, (c <= 5) ? 32'd14 : 32'd12);
      if (c > 5) chk("eret_wd", cp0_wd, stat);
      chk("eret_ack", {31'b0, sw_ack}, 32'd0);
      chk("eret_rv", {31'b0, redirect_valid}, 32'd0);
      step();
    end
    chk("eret_redir_v", {31'b0, redirect_valid}, 32'd1);
    chk("eret_redir_pc", redirect_pc, target);
    step();
    chk("eret_idle_rv", {31'b0, redirect_valid}, 32'd0);
  endtask

  // Accept edge, write 1..5 with ack on 5, idle 6
  task automatic sw_seq(input logic [4:0] addr, input logic [31:0] data);
    step();
    for (int c = 1; c <= 5; c++) begin
      chk("sw_w", {31'b0, cp0_w}, 32'd1);
      chk("sw_a1", {27'b0, cp0_a1}, {27'b0, addr});
      chk("sw_wd", cp0_wd, data);
      chk("sw_ack", {31'b0, sw_ack}, (c == 5) ? 32'd1 : 32'd0);
      chk("sw_rv", {31'b0, redirect_valid}, 32'd0);
      if (c == 5) sw_wr = 1'b0;
      step();
    end
    chk("sw_idle_ack", {31'b0, sw_ack}, 32'd0);
    chk("sw_idle_w", {31'b0, cp0_w}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; exc_req = 1'b0; exc_code = 5'd0; exc_pc = 32'b0; exc_bd = 1'b0;
    int_pc = 32'b0; hw_int = 6'b0; eret_req = 1'b0; sw_wr = 1'b0;
    sw_addr = 5'd7; sw_wdata = 32'b0; cp0_rd1 = 32'b0;

    // Reset
    step();
    chk("rst_w", {31'b0, cp0_w}, 32'd0);
    chk("rst_wd", cp0_wd, 32'd0);
    chk("rst_ack", {31'b0, sw_ack}, 32'd0);
    chk("rst_rv", {31'b0, redirect_valid}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_a1", {27'b0, cp0_a1}, 32'd7);
    reset = 1'b1;
    step();
    sw_addr = 5'd3;
    #1;
    chk("idle_a1_comb", {27'b0, cp0_a1}, 32'd3);

    // Exception in delay slot
    exc_req = 1'b1; exc_code = 5'd4; exc_pc = 32'h0040_0010; exc_bd = 1'b1;
    #1;
    chk("exc_req_stall", {31'b0, stall}, 32'd1);
    exc_seq(32'h0040_000C, 32'h8000_0010, 32'h0000_0002);

    // mtc0 Status then hardware interrupt
    sw_wr = 1'b1; sw_addr = 5'd12; sw_wdata = 32'h0000_0401;
    sw_seq(5'd12, 32'h0000_0401);
    hw_int = 6'b000001; int_pc = 32'h0040_0200;
    #1;
    chk("int_pend_stall", {31'b0, stall}, 32'd1);
    exc_seq(32'h0040_0200, 32'h0000_0400, 32'h0000_0403);

    // eret
    cp0_rd1 = 32'h0040_0100; eret_req = 1'b1;
    eret_seq(32'h0000_0401, 32'h0040_0100);
    chk("eret_done_stall", {31'b0, stall}, 32'd0);

    // Simultaneous exception, eret, mtc0
    exc_req = 1'b1; exc_code = 5'd12; exc_pc = 32'h0000_1000; exc_bd = 1'b0;
    eret_req = 1'b1; cp0_rd1 = 32'h0000_2000;
    sw_wr = 1'b1; sw_addr = 5'd9; sw_wdata = 32'hDEAD_BEEF;
    exc_seq(32'h0000_1000, 32'h0000_0030, 32'h0000_0403);
    eret_seq(32'h0000_0401, 32'h0000_2000);
    chk("sim_sw_nostall", {31'b0, stall}, 32'd0);
    sw_seq(5'd9, 32'hDEAD_BEEF);

    // Reset during W_CAUSE
    exc_req = 1'b1; exc_code = 5'd1; exc_pc = 32'h0000_3000; exc_bd = 1'b0;
    step();
    exc_req = 1'b0;
    for (int c = 2; c <= 7; c++) step();
    chk("mid_w", {31'b0, cp0_w}, 32'd1);
    chk("mid_a1", {27'b0, cp0_a1}, 32'd13);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_w", {31'b0, cp0_w}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall}, 32'd0);
    for (int c = 0; c < 12; c++) begin
      chk("abandon_w", {31'b0, cp0_w}, 32'd0);
      chk("abandon_rv", {31'b0, redirect_valid}, 32'd0);
      step();
    end
    hw_int = 6'b000001;
    #1;
    chk("shadow_clr_noint", {31'b0, stall}, 32'd0);
    hw_int = 6'b0;
    cp0_rd1 = 32'h0000_4000; eret_req = 1'b1;
    eret_seq(32'h0000_0000, 32'h0000_4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
